placar_pontos: RTL

PLACAR_PONTOS -- requirements
Module: placar_pontos

---
 rtl/placar_pontos_pkg.sv | 27 ++
 rtl/placar_pontos_detector_borda.sv | 26 ++
 rtl/placar_pontos.sv | 126 ++++++++++++
 3 files changed

// File: rtl/placar_pontos_pkg.sv
// Shared definitions for the rhythm-game scoreboard: FSM encoding,
// multiplier thresholds and the score width.
package placar_pontos_pkg;

    typedef enum logic [1:0] {
        OCIOSO  = 2'b00,
        JOGANDO = 2'b01,
        FIM     = 2'b10
    } estado_t;

    localparam int unsigned LARGURA_PONTOS = 7;
    localparam int unsigned LARGURA_COMBO  = 4;

    localparam logic [LARGURA_COMBO-1:0] LIMIAR_MULT2 = 4'd4;
    localparam logic [LARGURA_COMBO-1:0] LIMIAR_MULT3 = 4'd8;

    // Points awarded by the next hit, derived from the current combo
    function automatic logic [1:0] calc_multiplicador(input logic [LARGURA_COMBO-1:0] c);
        if (c >= LIMIAR_MULT3)
            return 2'd3;
        else if (c >= LIMIAR_MULT2)
            return 2'd2;
        else
            return 2'd1;
    endfunction

endpackage

// File: rtl/placar_pontos_detector_borda.sv
// Registered rising-edge detector: one-cycle pulse the cycle after a 0->1 sample.
module detector_borda (
    input  logic clock,
    input  logic zera_as_n,
    input  logic sinal,
    output logic pulso
);

    logic r_anterior;
    logic r_pulso;

    // History register and registered pulse; history clears on reset so a
    // level already high at release yields one event
    always_ff @(posedge clock or negedge zera_as_n) begin
        if (!zera_as_n) begin
            r_anterior <= 1'b0;
            r_pulso    <= 1'b0;
        end else begin
            r_anterior <= sinal;
            r_pulso    <= sinal & ~r_anterior;
        end
    end

    assign pulso = r_pulso;

endmodule

// File: rtl/placar_pontos.sv
// Scoreboard for a rhythm game: edge-detected controls, score/combo
// datapath with saturation, and best-score tracking across matches.
module placar_pontos
    import placar_pontos_pkg::*;
#(
    parameter int unsigned PONTOS_MAX = 99,
    parameter int unsigned COMBO_MAX  = 15
) (
    input  logic                      clock,
    input  logic                      zera_as_n,
    input  logic                      iniciar,
    input  logic                      fim_partida,
    input  logic                      acerto,
    input  logic                      erro,
    output logic [LARGURA_PONTOS-1:0] pontos,
    output logic [LARGURA_COMBO-1:0]  combo,
    output logic [1:0]                multiplicador,
    output logic [LARGURA_PONTOS-1:0] recorde,
    output logic                      novo_recorde,
    output logic                      jogando
);

    localparam logic [7:0]               PMAX = 8'(PONTOS_MAX);
    localparam logic [LARGURA_COMBO-1:0] CMAX = LARGURA_COMBO'(COMBO_MAX);

    logic w_ini, w_fim, w_acerto, w_erro;

    detector_borda u_borda_ini    (.clock(clock), .zera_as_n(zera_as_n), .sinal(iniciar),     .pulso(w_ini));
    detector_borda u_borda_fim    (.clock(clock), .zera_as_n(zera_as_n), .sinal(fim_partida), .pulso(w_fim));
    detector_borda u_borda_acerto (.clock(clock), .zera_as_n(zera_as_n), .sinal(acerto),      .pulso(w_acerto));
    detector_borda u_borda_erro   (.clock(clock), .zera_as_n(zera_as_n), .sinal(erro),        .pulso(w_erro));

    estado_t                   r_estado;
    logic [LARGURA_PONTOS-1:0] r_pontos;
    logic [LARGURA_COMBO-1:0]  r_combo;
    logic [LARGURA_PONTOS-1:0] r_recorde;
    logic                      r_novo_recorde;
    logic                      r_jogando;
    logic                      r_avaliar;

    logic [1:0]                w_mult;
    logic [7:0]                w_soma;
    logic [LARGURA_PONTOS-1:0] w_pontos_acerto;
    logic [LARGURA_PONTOS-1:0] w_pontos_erro;
    logic [LARGURA_COMBO-1:0]  w_combo_inc;

    // Next-value candidates: saturating add (8-bit, cannot wrap) and floor-at-zero subtract
    always_comb begin
        w_mult          = calc_multiplicador(r_combo);
        w_soma          = {1'b0, r_pontos} + {6'b0, w_mult};
        w_pontos_acerto = (w_soma > PMAX) ? PMAX[LARGURA_PONTOS-1:0] : w_soma[LARGURA_PONTOS-1:0];
        w_pontos_erro   = (r_pontos == '0) ? '0 : r_pontos - 7'd1;
        w_combo_inc     = (r_combo >= CMAX) ? CMAX : r_combo + 4'd1;
    end

    // Match FSM with registered outputs; the record compare is deferred one
    // cycle after entering FIM so a score update on the same edge is seen
    always_ff @(posedge clock or negedge zera_as_n) begin
        if (!zera_as_n) begin
            r_estado       <= OCIOSO;
            r_pontos       <= '0;
            r_combo        <= '0;
            r_recorde      <= '0;
            r_novo_recorde <= 1'b0;
            r_jogando      <= 1'b0;
            r_avaliar      <= 1'b0;
        end else begin
            case (r_estado)
                OCIOSO: begin
                    if (w_ini) begin
                        r_estado       <= JOGANDO;
                        r_pontos       <= '0;
                        r_combo        <= '0;
                        r_novo_recorde <= 1'b0;
                        r_jogando      <= 1'b1;
                    end
                end
                JOGANDO: begin
                    if (w_erro) begin
                        r_pontos <= w_pontos_erro;
                        r_combo  <= '0;
                    end else if (w_acerto) begin
                        r_pontos <= w_pontos_acerto;
                        r_combo  <= w_combo_inc;
                    end
                    if (w_fim) begin
                        r_estado       <= FIM;
                        r_jogando      <= 1'b0;
                        r_avaliar      <= 1'b1;
                        r_novo_recorde <= 1'b0;
                    end
                end
                FIM: begin
                    if (r_avaliar) begin
                        r_avaliar <= 1'b0;
                        if (r_pontos > r_recorde) begin
                            r_recorde      <= r_pontos;
                            r_novo_recorde <= 1'b1;
                        end
                    end
                    if (w_ini) begin
                        r_estado       <= JOGANDO;
                        r_pontos       <= '0;
                        r_combo        <= '0;
                        r_novo_recorde <= 1'b0;
                        r_jogando      <= 1'b1;
                        r_avaliar      <= 1'b0;
                    end
                end
                default: begin
                    r_estado  <= OCIOSO;
                    r_jogando <= 1'b0;
                    r_avaliar <= 1'b0;
                end
            endcase
        end
    end

    assign pontos        = r_pontos;
    assign combo         = r_combo;
    assign multiplicador = w_mult;
    assign recorde       = r_recorde;
    assign novo_recorde  = r_novo_recorde;
    assign jogando       = r_jogando;

endmodule
